// File: rtl/register_file_pkg.sv
// Shared datapath constants and types for the general-purpose register file.
// The read ports and the storage top both import this package.
package register_file_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int ZERO_REG   = 0;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational operand-fetch port.
// It selects a stored entry, then applies the zero-register rule and the optional write bypass.
module regfile_read_port #(
  parameter int DATA_WIDTH  = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = register_file_pkg::ADDR_WIDTH,
  parameter int DEPTH       = 1 << ADDR_WIDTH,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] entries [DEPTH],
  input  logic                  byp_valid,
  input  logic [ADDR_WIDTH-1:0] byp_addr,
  input  logic [DATA_WIDTH-1:0] byp_data,
  output logic [DATA_WIDTH-1:0] data
);
  import register_file_pkg::*;

  // The zero register wins over the bypass, so a write aimed at entry 0 never leaks through.
  always_comb begin
    data = entries[addr];
    if (ZERO_REG_EN && (addr == ADDR_WIDTH'(ZERO_REG))) begin
      data = '0;
    end else if (byp_valid && (addr == byp_addr)) begin
      data = byp_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 64 general-purpose register file: two combinational read ports and one rising-edge write port.
// Reset clears every entry asynchronously.
module register_file #(
  parameter int DATA_WIDTH  = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = register_file_pkg::ADDR_WIDTH,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter bit BYPASS_EN   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read1,
  input  logic [ADDR_WIDTH-1:0] read2,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  logic                  WEn,
  input  logic [DATA_WIDTH-1:0] Write_data,
  output logic [DATA_WIDTH-1:0] Data1,
  output logic [DATA_WIDTH-1:0] Data2
);
  import register_file_pkg::*;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_fire;
  logic                  byp_valid;

  // Writes to the hardwired zero entry are dropped, so that entry stays at its reset value.
  assign wr_fire   = WEn && !(ZERO_REG_EN && (write_register == ADDR_WIDTH'(ZERO_REG)));
  // The bypass is masked during reset so both ports read 0 while rst is high.
  assign byp_valid = BYPASS_EN && WEn && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[write_register] <= Write_data;
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .ZERO_REG_EN(ZERO_REG_EN)
  ) u_port1 (
    .addr     (read1),
    .entries  (mem),
    .byp_valid(byp_valid),
    .byp_addr (write_register),
    .byp_data (Write_data),
    .data     (Data1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .ZERO_REG_EN(ZERO_REG_EN)
  ) u_port2 (
    .addr     (read2),
    .entries  (mem),
    .byp_valid(byp_valid),
    .byp_addr (write_register),
    .byp_data (Write_data),
    .data     (Data2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file with default parameters (zero register on, bypass off).
// Inputs change on the falling edge, and outputs are sampled 1 time unit after a change or a rising edge.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  read1;
  logic [4:0]  read2;
  logic [4:0]  write_register;
  logic        WEn;
  logic [63:0] Write_data;
  logic [63:0] Data1;
  logic [63:0] Data2;

  int checks = 0;
  int errors = 0;

  register_file dut (
    .clk           (clk),
    .rst           (rst),
    .read1         (read1),
    .read2         (read2),
    .write_register(write_register),
    .WEn           (WEn),
    .Write_data    (Write_data),
    .Data1         (Data1),
    .Data2         (Data2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input logic [4:0] addr, input logic [63:0] data);
    @(negedge clk);
    WEn            = 1'b1;
    write_register = addr;
    Write_data     = data;
    @(posedge clk);
    #1;
    WEn = 1'b0;
  endtask

  task automatic read_pair(input logic [4:0] a1, input logic [4:0] a2);
    read1 = a1;
    read2 = a2;
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    read1          = '0;
    read2          = '0;
    write_register = '0;
    WEn            = 1'b0;
    Write_data     = '0;

    // Reset: data reads 0 while rst is held, and every address reads 0 after rst is released.
    #2;
    read_pair(5'd4, 5'd30);
    check("rst_held_d1", Data1, 64'h0);
    check("rst_held_d2", Data2, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_pair(5'(i), 5'(31 - i));
      check($sformatf("reset_d1_a%0d", i), Data1, 64'h0);
      check($sformatf("reset_d2_a%0d", 31 - i), Data2, 64'h0);
    end

    // Basic write and read.
    write_entry(5'd5, 64'h6);
    write_entry(5'd3, 64'hABCDFE);
    @(negedge clk);
    read_pair(5'd5, 5'd3);
    check("basic_d1_r5", Data1, 64'h6);
    check("basic_d2_r3", Data2, 64'h0000_0000_00AB_CDFE);

    // Same address on both ports.
    read_pair(5'd3, 5'd3);
    check("same_addr_d1", Data1, 64'h0000_0000_00AB_CDFE);
    check("same_addr_d2", Data2, 64'h0000_0000_00AB_CDFE);

    // Write disabled: several edges with WEn low must change nothing.
    @(negedge clk);
    WEn            = 1'b0;
    write_register = 5'd7;
    Write_data     = 64'd26;
    repeat (3) @(posedge clk);
    @(negedge clk);
    read_pair(5'd7, 5'd5);
    check("wen0_r7", Data1, 64'h0);
    check("wen0_r5", Data2, 64'h6);
    read_pair(5'd3, 5'd7);
    check("wen0_r3", Data1, 64'h0000_0000_00AB_CDFE);
    check("wen0_r7_p2", Data2, 64'h0);

    // Zero register ignores writes on both ports.
    write_entry(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    read_pair(5'd0, 5'd0);
    check("zero_reg_d1", Data1, 64'h0);
    check("zero_reg_d2", Data2, 64'h0);

    // Highest address is ordinary storage.
    write_entry(5'd31, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    read_pair(5'd31, 5'd30);
    check("top_addr_r31", Data1, 64'h0123_4567_89AB_CDEF);
    check("top_addr_r30", Data2, 64'h0);

    // Read during write without bypass: the old value stays visible until the edge.
    write_entry(5'd9, 64'h11);
    @(negedge clk);
    read_pair(5'd1, 5'd9);
    check("rdw_initial", Data2, 64'h11);
    WEn            = 1'b1;
    write_register = 5'd9;
    Write_data     = 64'h22;
    #1;
    check("rdw_before_edge", Data2, 64'h11);
    @(posedge clk);
    #1;
    WEn = 1'b0;
    check("rdw_after_edge", Data2, 64'h22);

    // Overwriting an entry replaces its value and leaves its neighbours alone.
    write_entry(5'd5, 64'hFEED_FACE_0000_0001);
    @(negedge clk);
    read_pair(5'd5, 5'd3);
    check("overwrite_r5", Data1, 64'hFEED_FACE_0000_0001);
    check("overwrite_r3", Data2, 64'h0000_0000_00AB_CDFE);

    // Async reset mid-cycle clears the entry with no clock edge, and reset wins over a write.
    write_entry(5'd31, 64'hDEAD);
    @(negedge clk);
    read_pair(5'd31, 5'd9);
    check("pre_rst_r31", Data1, 64'hDEAD);
    #2;
    rst            = 1'b1;
    WEn            = 1'b1;
    write_register = 5'd31;
    Write_data     = 64'hBEEF;
    #1;
    check("async_rst_r31", Data1, 64'h0);
    check("async_rst_r9", Data2, 64'h0);
    @(posedge clk);
    #1;
    check("rst_over_write", Data1, 64'h0);
    @(negedge clk);
    WEn = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_r31", Data1, 64'h0);
    read_pair(5'd5, 5'd3);
    check("post_rst_r5", Data1, 64'h0);
    check("post_rst_r3", Data2, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
